// File: rtl/parity_link_pkg.sv
// Shared definitions for the XOR-parity serial link (receiver and transmitter).
// Contents: FSM state encoding, line-level constants, frame length helper.
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } link_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Start + data + parity + stop: cycles per frame on the line.
    function automatic int frame_len(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Output word port of the parity frame receiver.
// master: producer side (receiver) drives word, flags and valid; reads ready.
// slave : consumer side reads word, flags and valid; drives ready.
interface parity_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_parity_err;
    logic              out_frame_err;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_parity_err,
        output out_frame_err,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_parity_err,
        input  out_frame_err,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator with synchronous clear, shared by the link's parity
// checker and parity generator.
// Ports: clk, rst_n (sync, active-low), clr (clear, has priority),
//        en (fold bit_in into acc), bit_in, acc (running XOR).
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver with XOR parity and stop-bit checking.
// Frame on the line: start(0), DATA_W data bits LSB first, parity, stop(1).
// Ports: clk, rst_n (sync, active-low), serial_in (idles high),
//        port (word/flags with valid/ready, master side),
//        overrun (one-cycle pulse when a completed frame is dropped),
//        busy (FSM not in IDLE).
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// DATA   | shifting in data bits, counter = bit position
// PARITY | folding the parity bit into the accumulator
// STOP   | sampling stop bit, frame completes and is delivered or dropped
module parity_frame_rx
    import parity_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_in,
    parity_frame_rx_if.master       port,
    output logic                    overrun,
    output logic                    busy
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    link_state_t       state;
    link_state_t       state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;
    logic              shift_en;
    logic              frame_done;

    logic [DATA_W-1:0] hold_data;
    logic              hold_perr;
    logic              hold_ferr;
    logic              hold_valid;
    logic              accept;
    logic              load;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (serial_in == START_BIT) state_nxt = DATA;
            DATA:    if (bit_cnt == LAST_BIT)    state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                acc_clr = (serial_in == START_BIT);
            end
            DATA: begin
                busy     = 1'b1;
                acc_en   = 1'b1;
                shift_en = 1'b1;
            end
            PARITY: begin
                busy   = 1'b1;
                acc_en = 1'b1;
            end
            STOP: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    parity_acc u_parity_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (serial_in),
        .acc    (acc)
    );

    // Every position is rewritten each frame, so stale bits never leak.
    always_comb begin
        shift_nxt = shift_reg;
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt == CNT_W'(i)) shift_nxt[i] = serial_in;
        end
    end

    // Counter is wide enough to hold DATA_W, so it stops short of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (acc_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= shift_nxt;
            end
        end
    end

    // A completing frame may replace the held word in the same cycle it is
    // accepted; otherwise a full, unaccepted holding register drops it.
    assign accept = hold_valid && port.out_ready;
    assign load   = frame_done && (!hold_valid || port.out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_perr  <= 1'b0;
            hold_ferr  <= 1'b0;
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= frame_done && hold_valid && !port.out_ready;
            if (load) begin
                hold_data  <= shift_reg;
                hold_perr  <= acc ^ PARITY_ODD;
                hold_ferr  <= (serial_in != STOP_BIT);
                hold_valid <= 1'b1;
            end else if (accept) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign port.out_data       = hold_data;
    assign port.out_parity_err = hold_perr;
    assign port.out_frame_err  = hold_ferr;
    assign port.out_valid      = hold_valid;

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver and parity checker: the receiving end of the team's XOR-parity serial link. Samples one bit per clock from a line that idles high and detects a start bit. Shifts in DATA_W data bits LSB-first, checks the parity bit by XOR reduction, and checks the stop bit. Presents each received word on a valid/ready output port with per-word error flags.

## Interface
- DATA_W, default 8: data bits per frame; legal range 1–32.
- PARITY_ODD, default 0: 0 selects even parity (XOR of data and parity bits must be 0); 1 selects odd parity (must be 1).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- serial_in  in  1  line input, one bit per cycle; idle level 1.
- out_data  out  DATA_W  received word, valid while out_valid=1.
- out_parity_err  out  1  parity mismatch for the word in out_data.
- out_frame_err  out  1  stop bit was 0 for the word in out_data.
- out_valid  out  1  word held and available.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- overrun  out  1  one-cycle pulse when a completed frame was dropped.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: serial_in=0 → DATA, bit counter cleared, parity accumulator cleared. Otherwise stay in IDLE.
- DATA: shift serial_in into the shift register at bit position = counter (LSB first) and XOR it into the accumulator. After DATA_W bits → PARITY.
- PARITY: XOR serial_in into the accumulator → STOP.
- STOP: sample serial_in as the stop bit → IDLE.
  - The frame completes in this cycle.
  - parity_err = acc ^ PARITY_ODD.
  - frame_err = ~stop bit.
- Completion delivery:
  - Holding register empty, or out_ready=1 this cycle: load the word and flags; out_valid=1 next cycle.
  - Holding register full and out_ready=0: drop the new frame, keep the held word, pulse overrun for one cycle.
- Errored frames are delivered, not dropped; flags accompany the data.
- Handshake:
  - out_data and the flags stay stable while out_valid && !out_ready.
  - out_valid clears the cycle after acceptance unless a new word loads in the same cycle.
- Start detection does not depend on the output port. The receiver never stalls the line.
- Reset values: out_valid=0, out_data=0, out_parity_err=0, out_frame_err=0, overrun=0, busy=0; FSM in IDLE.
- Reset mid-frame: the partial frame is discarded and any held word is discarded. A 0 on serial_in in the first cycle after reset release is treated as a start bit.

## Timing
- Start bit sampled in cycle S. Data bits occupy S+1..S+DATA_W, parity S+DATA_W+1, stop S+DATA_W+2.
- out_valid rises in cycle S+DATA_W+3. For DATA_W=8: start at S, out_valid at S+11.
- Back-to-back frames: the next start bit may be sampled in cycle S+DATA_W+3 (IDLE entered that cycle). A frame therefore takes DATA_W+3 cycles.
- overrun is high in cycle S+DATA_W+3 only.
- Same-cycle acceptance and completion: the old word retires and the new word is visible next cycle, with out_valid continuously high and no overrun.
- The bit counter is $clog2(DATA_W+1) bits wide. It never wraps mid-frame.

## Structure
- Shared package parity_link_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1;
  - a frame_len(DATA_W) constant function returning DATA_W+3.
- The transmitter reuses the same package.
- One sub-module, parity_acc: a 1-bit XOR accumulator with a clear input. Shared with the transmitter's parity generator.
- Output holding register and flags live in the top module.

## Test plan
- Even parity, DATA_W=8. Send 0xA5 as bit stream 0,1,0,1,0,0,1,0,1,0,1 starting at cycle S, out_ready=1. Required: out_valid at S+11 with out_data=0xA5, parity_err=0, frame_err=0.
- Same frame with the parity bit flipped to 1 → out_data=0xA5, parity_err=1. Then stop bit 0 on 0x3C → out_data=0x3C, frame_err=1.
- out_ready=0. Send 0x11 then 0x22 back-to-back → out_data stays 0x11, overrun pulses once at completion of 0x22. Then raise out_ready → 0x11 accepted, out_valid drops.
- out_ready pulsed exactly in the completion cycle of the second of two frames (0x55, 0xAA) → 0x55 accepted, 0xAA shown next cycle, no overrun.
- rst_n low for one cycle in the middle of the data bits of 0xFF → busy=0 and out_valid=0 the cycle after reset. The next clean frame 0x0F is received correctly.
- PARITY_ODD=1, DATA_W=5. Send 0x1F with parity bit 0 → parity_err=0. Send 0x1F with parity bit 1 → parity_err=1.
